mb_param: RTL and testbench
===========================

# mb_param

Parametrised metadata buffer between queue selection (QS) and transmit scheduling (TS). Holds QNUM independent first-word-fall-through metadata queues in internal register arrays, so no vendor FIFO IP is required. Exposes head words, empty/full flags and fill levels to gate control (GC) and LCM. On a TS read request it pops exactly one queue and emits a registered metadata word tagged with its queue id. Collisions, overflow and underflow are handled deterministically.

## Interface
Parameters:
- QNUM, 4, number of queues (2..8)
- MD_W, 16, metadata width per queue
- OUT_W, 8, width of emitted metadata; out_md = head[OUT_W-1:0], OUT_W <= MD_W
- DEPTH, 16, entries per queue, power of two (4..64)
- Derived: CW = log2(DEPTH)+1 (fill-count width), QW = max(1, log2(QNUM)) (queue-id width)

Ports:
- clk  in  1  single clock; all logic on its rising edge
- srst  in  1  reset, synchronous, active-high
- in_md  in  QNUM*MD_W  write data; queue q occupies bits [q*MD_W +: MD_W]
- in_md_wr  in  QNUM  per-queue write strobe
- in_rden  in  QNUM  per-queue read request from TS
- out_head  out  QNUM*MD_W  current head word of each queue (FWFT); 0 when that queue is empty
- out_empty  out  QNUM  queue empty
- out_full  out  QNUM  queue holds DEPTH entries
- out_used_cnt  out  QNUM*CW  per-queue fill level, 0..DEPTH
- out_md  out  OUT_W  registered emitted metadata
- out_md_wr  out  1  out_md valid, one-cycle pulse per pop
- out_md_qid  out  QW  queue that produced out_md
- out_rd_err  out  1  one-cycle pulse: read collision, or read of an empty queue
- out_drop_cnt  out  QNUM*16  per-queue overflow drop counters (only with MB_DROP_CNT_EN)

## Operation
- Each queue has a circular buffer with rd_ptr/wr_ptr of log2(DEPTH) bits that wrap modulo DEPTH, plus a CW-bit count.
- Write, queue q: accepted if !full, or if full and q is popped in the same cycle. Otherwise the word is dropped and the queue is unchanged.
- Read arbitration: among the asserted in_rden bits, the lowest index wins. Only the winner is popped.
  - Losing requests are ignored: no pop, out_rd_err=1.
- Pop of an empty queue: ignored, out_md_wr=0, out_rd_err=1.
  - This holds even when the same queue is written that cycle, because the write is not yet visible.
- Simultaneous write and pop on the same non-empty queue: count unchanged, both pointers advance.
- Output register on a valid pop: out_md <= head[OUT_W-1:0], out_md_qid <= q, out_md_wr <= 1.
- Otherwise out_md <= 0, out_md_qid <= 0, out_md_wr <= 0.
- out_head, out_empty, out_full and out_used_cnt are driven combinationally from state registers. No input-to-output combinational path.
- Reset values: all pointers and counts 0, out_empty all 1, out_full 0, out_used_cnt 0, out_head 0, out_md 0, out_md_wr 0, out_md_qid 0, out_rd_err 0, drop counters 0.
- Reset applied mid-operation: all queue contents are discarded on that edge. Writes and reads presented in the reset cycle are ignored.

## Timing
- Write at edge t: the entry is visible on out_head, out_used_cnt and out_empty after edge t. A pop is legal from cycle t+1.
- Pop request in cycle t: out_md/out_md_wr are valid after edge t (one-cycle latency).
  - out_md carries the head word sampled in cycle t.
  - The next head appears on out_head in cycle t+1.
- Back-to-back pops of one queue every cycle are supported at full rate.
- out_rd_err is registered: asserted in cycle t+1 for an offending request in cycle t.

## Configuration
- MB_DROP_CNT_EN defined:
  - Each queue has a 16-bit drop counter on out_drop_cnt[q*16 +: 16].
  - It increments once per dropped write and saturates at 16'hFFFF.
  - It is cleared only by srst.
- MB_DROP_CNT_EN undefined: the out_drop_cnt port is absent and no counter logic is generated. Drop behaviour is otherwise identical.

## Test plan
- Defaults. Write 0x1234 to q2, then pulse in_rden[2] -> out_md=0x34, out_md_qid=2, out_md_wr=1 exactly one cycle after the request; q2 used_cnt goes 1 -> 0; out_empty[2]=1.
- Fill q0 with 16 writes, then write a 17th -> out_full[0]=1, used_cnt=16, 17th word lost; drop_cnt q0=1 with the macro.
  - Then simultaneous write + pop on full q0 -> write accepted, used_cnt stays 16.
- in_rden=4'b1010 with q1 and q3 non-empty -> q1 popped with qid=1, q3 count unchanged, out_rd_err=1.
- Pop of empty q3 while writing q3 in the same cycle -> out_md_wr=0, out_rd_err=1; q3 used_cnt=1 next cycle.
- Write 40 words through q1 with interleaved pops, never exceeding 16 entries -> output order identical to input order across pointer wrap.
- Assert srst with q0 holding 5 entries -> next cycle used_cnt=0, out_empty=4'b1111, drop counters 0; a pop in the reset cycle produces no out_md_wr.

Source files
------------

// File: rtl/mb_param.sv
// mb_param: metadata buffer between queue selection and transmit scheduling.
// Holds QNUM first-word-fall-through queues in register arrays. Each queue exposes
// its head word, empty/full flags and fill level. A read request pops one queue
// (the lowest requesting index) and emits a registered, queue-tagged word.
// Optional feature macro: MB_DROP_CNT_EN adds saturating per-queue overflow drop
// counters on out_drop_cnt.
module mb_param #(
  parameter int QNUM  = 4,
  parameter int MD_W  = 16,
  parameter int OUT_W = 8,
  parameter int DEPTH = 16
) (
  input  logic                                    clk,
  input  logic                                    srst,
  input  logic [QNUM*MD_W-1:0]                    in_md,
  input  logic [QNUM-1:0]                         in_md_wr,
  input  logic [QNUM-1:0]                         in_rden,
  output logic [QNUM*MD_W-1:0]                    out_head,
  output logic [QNUM-1:0]                         out_empty,
  output logic [QNUM-1:0]                         out_full,
  output logic [QNUM*($clog2(DEPTH)+1)-1:0]       out_used_cnt,
  output logic [OUT_W-1:0]                        out_md,
  output logic                                    out_md_wr,
  output logic [((QNUM > 1) ? $clog2(QNUM) : 1)-1:0] out_md_qid,
  output logic                                    out_rd_err
`ifdef MB_DROP_CNT_EN
  ,
  output logic [QNUM*16-1:0]                      out_drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int QW = (QNUM > 1) ? $clog2(QNUM) : 1;

  // Queue state
  logic [MD_W-1:0] mem_q    [QNUM][DEPTH];
  logic [AW-1:0]   rd_ptr_q [QNUM];
  logic [AW-1:0]   rd_ptr_d [QNUM];
  logic [AW-1:0]   wr_ptr_q [QNUM];
  logic [AW-1:0]   wr_ptr_d [QNUM];
  logic [CW-1:0]   cnt_q    [QNUM];
  logic [CW-1:0]   cnt_d    [QNUM];

  // Output register state
  logic [OUT_W-1:0] md_q, md_d;
  logic             md_wr_q, md_wr_d;
  logic [QW-1:0]    qid_q, qid_d;
  logic             rd_err_q, rd_err_d;

  // Combinational helpers
  logic [MD_W-1:0]  head_s [QNUM];
  logic [QNUM-1:0]  grant_s;
  logic [QNUM-1:0]  pop_s;
  logic [QNUM-1:0]  wr_acc_s;
  logic [QNUM-1:0]  drop_s;
  logic             collide_s;
  logic             valid_pop_s;

  // Head words and status flags, derived only from registered state
  always_comb begin
    out_head     = {(QNUM*MD_W){1'b0}};
    out_empty    = {QNUM{1'b0}};
    out_full     = {QNUM{1'b0}};
    out_used_cnt = {(QNUM*CW){1'b0}};
    for (int q = 0; q < QNUM; q++) begin
      if (cnt_q[q] != {CW{1'b0}}) begin
        head_s[q] = mem_q[q][rd_ptr_q[q]];
      end else begin
        head_s[q] = {MD_W{1'b0}};
      end
      out_head[q*MD_W +: MD_W] = head_s[q];
      out_empty[q]             = (cnt_q[q] == {CW{1'b0}});
      out_full[q]              = (cnt_q[q] == CW'(DEPTH));
      out_used_cnt[q*CW +: CW] = cnt_q[q];
    end
  end

  // Read arbitration: lowest requesting index wins; empty winner is not popped
  always_comb begin
    grant_s     = in_rden & (~in_rden + {{(QNUM-1){1'b0}}, 1'b1});
    collide_s   = ((in_rden & ~grant_s) != {QNUM{1'b0}});
    pop_s       = {QNUM{1'b0}};
    md_d        = {OUT_W{1'b0}};
    qid_d       = {QW{1'b0}};
    for (int q = 0; q < QNUM; q++) begin
      pop_s[q] = grant_s[q] && (cnt_q[q] != {CW{1'b0}});
      if (pop_s[q]) begin
        md_d  = head_s[q][OUT_W-1:0];
        qid_d = QW'(q);
      end else begin
        md_d  = md_d;
        qid_d = qid_d;
      end
    end
    valid_pop_s = (pop_s != {QNUM{1'b0}});
    md_wr_d     = valid_pop_s;
    // Any losing request, or a winning request on an empty queue, is an error
    rd_err_d    = collide_s || ((in_rden != {QNUM{1'b0}}) && !valid_pop_s);
  end

  // Per-queue write acceptance and next pointer/count values
  always_comb begin
    for (int q = 0; q < QNUM; q++) begin
      wr_acc_s[q] = in_md_wr[q] && ((cnt_q[q] != CW'(DEPTH)) || pop_s[q]);
      drop_s[q]   = in_md_wr[q] && !wr_acc_s[q];
      if (pop_s[q]) begin
        rd_ptr_d[q] = rd_ptr_q[q] + AW'(1);
      end else begin
        rd_ptr_d[q] = rd_ptr_q[q];
      end
      if (wr_acc_s[q]) begin
        wr_ptr_d[q] = wr_ptr_q[q] + AW'(1);
      end else begin
        wr_ptr_d[q] = wr_ptr_q[q];
      end
      case ({wr_acc_s[q], pop_s[q]})
        2'b10:   cnt_d[q] = cnt_q[q] + CW'(1);
        2'b01:   cnt_d[q] = cnt_q[q] - CW'(1);
        default: cnt_d[q] = cnt_q[q];
      endcase
    end
  end

  // Queue storage; contents need no reset because counts gate visibility
  always_ff @(posedge clk) begin
    if (!srst) begin
      for (int q = 0; q < QNUM; q++) begin
        if (wr_acc_s[q]) begin
          mem_q[q][wr_ptr_q[q]] <= in_md[q*MD_W +: MD_W];
        end
      end
    end
  end

  // Pointer, count and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (srst) begin
      for (int q = 0; q < QNUM; q++) begin
        rd_ptr_q[q] <= {AW{1'b0}};
        wr_ptr_q[q] <= {AW{1'b0}};
        cnt_q[q]    <= {CW{1'b0}};
      end
      md_q     <= {OUT_W{1'b0}};
      md_wr_q  <= 1'b0;
      qid_q    <= {QW{1'b0}};
      rd_err_q <= 1'b0;
    end else begin
      for (int q = 0; q < QNUM; q++) begin
        rd_ptr_q[q] <= rd_ptr_d[q];
        wr_ptr_q[q] <= wr_ptr_d[q];
        cnt_q[q]    <= cnt_d[q];
      end
      md_q     <= md_d;
      md_wr_q  <= md_wr_d;
      qid_q    <= qid_d;
      rd_err_q <= rd_err_d;
    end
  end

  assign out_md     = md_q;
  assign out_md_wr  = md_wr_q;
  assign out_md_qid = qid_q;
  assign out_rd_err = rd_err_q;

`ifdef MB_DROP_CNT_EN
  logic [15:0] drop_cnt_q [QNUM];
  logic [15:0] drop_cnt_d [QNUM];

  // Saturating drop counters, stepped once per rejected write
  always_comb begin
    out_drop_cnt = {(QNUM*16){1'b0}};
    for (int q = 0; q < QNUM; q++) begin
      if (drop_s[q] && (drop_cnt_q[q] != 16'hFFFF)) begin
        drop_cnt_d[q] = drop_cnt_q[q] + 16'd1;
      end else begin
        drop_cnt_d[q] = drop_cnt_q[q];
      end
      out_drop_cnt[q*16 +: 16] = drop_cnt_q[q];
    end
  end

  // Drop counter registers, cleared only by reset
  always_ff @(posedge clk) begin
    if (srst) begin
      for (int q = 0; q < QNUM; q++) begin
        drop_cnt_q[q] <= 16'd0;
      end
    end else begin
      for (int q = 0; q < QNUM; q++) begin
        drop_cnt_q[q] <= drop_cnt_d[q];
      end
    end
  end
`else
  logic unused_drop_s;
  assign unused_drop_s = ^drop_s;
`endif

endmodule

// File: tb/tb_mb_param.sv
// Directed testbench for mb_param with default parameters.
// Drop-counter checks are compiled in only when MB_DROP_CNT_EN is defined.
module tb_mb_param;

  logic        clk;
  logic        srst;
  logic [63:0] in_md;
  logic [3:0]  in_md_wr;
  logic [3:0]  in_rden;
  logic [63:0] out_head;
  logic [3:0]  out_empty;
  logic [3:0]  out_full;
  logic [19:0] out_used_cnt;
  logic [7:0]  out_md;
  logic        out_md_wr;
  logic [1:0]  out_md_qid;
  logic        out_rd_err;
`ifdef MB_DROP_CNT_EN
  logic [63:0] out_drop_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  mb_param dut (
    .clk          (clk),
    .srst         (srst),
    .in_md        (in_md),
    .in_md_wr     (in_md_wr),
    .in_rden      (in_rden),
    .out_head     (out_head),
    .out_empty    (out_empty),
    .out_full     (out_full),
    .out_used_cnt (out_used_cnt),
    .out_md       (out_md),
    .out_md_wr    (out_md_wr),
    .out_md_qid   (out_md_qid),
    .out_rd_err   (out_rd_err)
`ifdef MB_DROP_CNT_EN
    ,
    .out_drop_cnt (out_drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] used(input int q);
    return out_used_cnt[q*5 +: 5];
  endfunction

  function automatic logic [15:0] head(input int q);
    return out_head[q*16 +: 16];
  endfunction

  task automatic set_md(input int q, input logic [15:0] d);
    in_md[q*16 +: 16] = d;
  endtask

  initial begin
    srst     = 1'b1;
    in_md    = 64'd0;
    in_md_wr = 4'd0;
    in_rden  = 4'd0;
    tick();
    tick();
    srst = 1'b0;

    // Reset state
    check("rst_empty", out_empty, 4'hF);
    check("rst_full", out_full, 4'h0);
    check("rst_used", out_used_cnt, 20'd0);
    check("rst_head", out_head, 64'd0);
    check("rst_md", {out_md_wr, out_md_qid, out_md}, 11'd0);
    check("rst_err", out_rd_err, 1'b0);

    // Single write/pop on q2
    set_md(2, 16'h1234);
    in_md_wr = 4'b0100;
    tick();
    in_md_wr = 4'b0000;
    check("q2_used1", used(2), 5'd1);
    check("q2_head", head(2), 16'h1234);
    check("q2_nonempty", out_empty[2], 1'b0);
    in_rden = 4'b0100;
    tick();
    in_rden = 4'b0000;
    check("q2_md", out_md, 8'h34);
    check("q2_qid", out_md_qid, 2'd2);
    check("q2_wr", out_md_wr, 1'b1);
    check("q2_err", out_rd_err, 1'b0);
    check("q2_used0", used(2), 5'd0);
    check("q2_empty", out_empty[2], 1'b1);
    check("q2_head0", head(2), 16'h0000);
    tick();
    check("q2_wr_pulse", out_md_wr, 1'b0);
    check("q2_md_clr", out_md, 8'h00);

    // Fill q0, overflow, then write+pop while full
    for (int i = 0; i < 16; i++) begin
      set_md(0, 16'h5A10 + 16'(i));
      in_md_wr = 4'b0001;
      tick();
    end
    in_md_wr = 4'b0000;
    check("q0_full", out_full[0], 1'b1);
    check("q0_used16", used(0), 5'd16);
    set_md(0, 16'hBEEF);
    in_md_wr = 4'b0001;
    tick();
    in_md_wr = 4'b0000;
    check("q0_ovf_used", used(0), 5'd16);
    check("q0_ovf_head", head(0), 16'h5A10);
`ifdef MB_DROP_CNT_EN
    check("q0_drop1", out_drop_cnt[15:0], 16'd1);
`endif
    set_md(0, 16'hC0DE);
    in_md_wr = 4'b0001;
    in_rden  = 4'b0001;
    tick();
    in_md_wr = 4'b0000;
    in_rden  = 4'b0000;
    check("q0_wp_md", {out_md_wr, out_md}, 9'h110);
    check("q0_wp_used", used(0), 5'd16);
    check("q0_wp_head", head(0), 16'h5A11);
`ifdef MB_DROP_CNT_EN
    check("q0_drop_keep", out_drop_cnt[15:0], 16'd1);
`endif
    // Drain: 0x11..0x1F then the word written while full
    for (int i = 1; i < 17; i++) begin
      in_rden = 4'b0001;
      tick();
      check($sformatf("q0_drain%0d", i), {out_md_wr, out_md},
            (i < 16) ? {1'b1, 8'h10 + 8'(i)} : 9'h1DE);
    end
    in_rden = 4'b0000;
    check("q0_drained", out_empty[0], 1'b1);

    // Collision: q1 and q3 requested, q1 wins
    set_md(1, 16'h1111);
    set_md(3, 16'h3333);
    in_md_wr = 4'b1010;
    tick();
    in_md_wr = 4'b0000;
    in_rden  = 4'b1010;
    tick();
    in_rden = 4'b0000;
    check("col_md", {out_md_wr, out_md_qid, out_md}, {1'b1, 2'd1, 8'h11});
    check("col_err", out_rd_err, 1'b1);
    check("col_q1", used(1), 5'd0);
    check("col_q3", used(3), 5'd1);
    in_rden = 4'b1000;
    tick();
    in_rden = 4'b0000;
    check("q3_pop", {out_md_wr, out_md_qid, out_md}, {1'b1, 2'd3, 8'h33});
    check("q3_pop_err", out_rd_err, 1'b0);

    // Pop of empty q3 while writing q3
    set_md(3, 16'h3A3A);
    in_md_wr = 4'b1000;
    in_rden  = 4'b1000;
    tick();
    in_md_wr = 4'b0000;
    in_rden  = 4'b0000;
    check("emp_wr", out_md_wr, 1'b0);
    check("emp_err", out_rd_err, 1'b1);
    check("emp_used", used(3), 5'd1);
    in_rden = 4'b1000;
    tick();
    in_rden = 4'b0000;
    check("emp_late_pop", {out_md_wr, out_md_qid, out_md}, {1'b1, 2'd3, 8'h3A});
    check("emp_err_clr", out_rd_err, 1'b0);

    // 40 words through q1 across pointer wrap, four in flight
    begin
      int exp_idx;
      exp_idx = 0;
      for (int i = 0; i < 44; i++) begin
        in_md_wr = (i < 40) ? 4'b0010 : 4'b0000;
        set_md(1, {8'hC1, 8'h40 + 8'(i)});
        in_rden = (i >= 4) ? 4'b0010 : 4'b0000;
        tick();
        if (i >= 4) begin
          check($sformatf("wrap%0d", exp_idx), {out_md_wr, out_md_qid, out_md},
                {1'b1, 2'd1, 8'h40 + 8'(exp_idx)});
          exp_idx++;
        end else begin
          check($sformatf("wrap_fill%0d", i), used(1), 5'(i + 1));
        end
      end
      in_md_wr = 4'b0000;
      in_rden  = 4'b0000;
      check("wrap_empty", out_empty[1], 1'b1);
    end

    // Reset with q0 holding 5 entries; pop and write in reset cycle ignored
    for (int i = 0; i < 5; i++) begin
      set_md(0, 16'h0700 + 16'(i));
      in_md_wr = 4'b0001;
      tick();
    end
    in_md_wr = 4'b0000;
    check("pre_rst_used", used(0), 5'd5);
    srst     = 1'b1;
    in_rden  = 4'b0001;
    in_md_wr = 4'b0010;
    tick();
    srst     = 1'b0;
    in_rden  = 4'b0000;
    in_md_wr = 4'b0000;
    check("mid_rst_used", out_used_cnt, 20'd0);
    check("mid_rst_empty", out_empty, 4'hF);
    check("mid_rst_mdwr", out_md_wr, 1'b0);
    check("mid_rst_err", out_rd_err, 1'b0);
`ifdef MB_DROP_CNT_EN
    check("mid_rst_drop", out_drop_cnt, 64'd0);
`endif
    tick();
    check("post_rst_used", out_used_cnt, 20'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
